store_narrow: RTL
=================

// Module: store_narrow
// PURPOSE
//  Store-side counterpart of the load sign-extension path: takes 32-bit store data from EX/MEM plus size/address,
//  truncates it to byte/half/word, replicates it onto the correct byte lanes and drives it to data memory with byte enables.
//  Holds stores in a small FIFO so the pipeline is not stalled by a slow memory; valid/ready on both sides.
// PARAMETERS
//  DEPTH   2   store buffer entries (power of 2, >=2)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous reset, active-high
//  req_valid  in   1   store request present
//  req_ready  out  1   buffer can accept (= !full)
//  req_addr   in   32  byte address
//  req_size   in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_data   in   32  store data, right-justified (value in low bits)
//  mem_valid  out  1   memory write beat valid
//  mem_ready  in   1   memory accepts beat
//  mem_addr   out  32  word address, [1:0] always 2'b00
//  mem_wdata  out  32  lane-aligned write data
//  mem_be     out  4   byte enables, bit i = byte lane i (bits [8i+7:8i])
//  err_valid  out  1   one-cycle pulse: request rejected
//  err_addr   out  32  req_addr of rejected request, held until next error
//  busy       out  1   buffer non-empty or beat outstanding
// BEHAVIOUR
//  - Reset: FIFO empty, mem_valid=0, mem_be=0, mem_wdata=0, mem_addr=0, err_valid=0, err_addr=0, busy=0, FSM=FIRST;
//    stores in flight (incl. half-done split) discarded. Reset mid-burst allowed.
//  - Accept on req_valid&&req_ready. req_ready=!full only; no same-cycle push when full even if popping.
//  - Check at accept: size 11 always rejected; half with addr[0]=1 or word with addr[1:0]!=0 is misaligned.
//    Rejected request not enqueued; err_valid=1 next cycle, err_addr=req_addr. Accepted = enqueued.
//  - Latency: accept in cycle N -> mem_valid earliest N+1 (registered outputs). FIFO is first-in-first-out.
//  - Lane mapping, o=addr[1:0]:
//    byte: wdata={4{data[7:0]}}, be=4'b0001<<o;
//    half: wdata={2{data[15:0]}}, be=o[1]?1100:0011;
//    word: wdata=data, be=1111.
//    Unused lanes carry replicated data, ignored by memory.
//  - mem_addr={addr[31:2],2'b00}. While mem_valid&&!mem_ready, mem_addr/wdata/be held stable; entry popped on handshake,
//    next entry presented the following cycle (one beat per cycle max, back-to-back allowed).
//  - FSM: FIRST (present beat 0) -> on handshake: pop if single-beat, else SECOND; SECOND -> on handshake: pop, FIRST.
//    Without split feature, SECOND is unreachable.
//  - Full: DEPTH entries -> req_ready=0. Empty: mem_valid=0. FIFO pointers wrap modulo DEPTH.
// CONFIGURATION
//  MISALIGN_SPLIT_EN defined:
//   - misaligned half/word accepted, not errored (size 11 still rejected);
//   - issued as two beats, n=bytes(2|4):
//     beat0 addr={a[31:2],00}, be=lanes o..3, wdata=data<<(8*o);
//     beat1 addr=beat0+4 (wraps 0xFFFFFFFC->0), be=lanes 0..(o+n-5), wdata=data>>(8*(4-o)).
//   - beats are consecutive; no other entry interleaves.
//  MISALIGN_SPLIT_EN undefined:
//   - misaligned half/word rejected via err_valid; split logic not compiled.
// TESTING
//  1 rst, SB addr=0x103 data=0xABCD12EF, mem_ready=1 -> next cyc mem_addr=0x100, be=1000, wdata=0xEFEFEFEF.
//  2 SH 0x202 data=0x5678, SW 0x300 data=0xDEADBEEF, mem_ready=0 5 cyc -> be=1100 wdata=0x56785678 held, req_ready=0
//    after 2nd accept (DEPTH=2); release -> SW beat be=1111 next cyc.
//  3 SW 0x401 without MISALIGN_SPLIT_EN -> no mem beat, err_valid 1 cyc, err_addr=0x401; size=11 -> same.
//  4 MISALIGN_SPLIT_EN: SW 0x401 data=0x11223344 -> beat0 0x400 be=1110 wdata=0x22334400;
//    beat1 0x404 be=0001 wdata[7:0]=0x11. SH 0xFFFFFFFF data=0xAABB -> beat0 be=1000 [31:24]=0xBB;
//    beat1 addr=0x0 be=0001 [7:0]=0xAA.
//  5 assert rst during split beat1 stall with full FIFO -> next cyc mem_valid=0, busy=0, req_ready=1; no stale beat later.
//  6 stream 8 SB, mem_ready=1 -> one beat/cycle, address order preserved, pointer wrap correct.

Source files
------------

// File: rtl/store_narrow.sv
// Store-path byte-lane steering with a DEPTH-entry store buffer between EX/MEM and data memory.
// Optional `MISALIGN_SPLIT_EN issues lane-crossing half/word stores as two consecutive beats.
module store_narrow #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        err_valid,
    output logic [31:0] err_addr,
    output logic        busy,
    output logic        dbg_state
);
    // Both ports use valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its payload are held stable until that edge, and ready never depends on the same side's valid.

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic {FIRST = 1'b0, SECOND = 1'b1} state_e;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata0;
        logic [3:0]  be0;
`ifdef MISALIGN_SPLIT_EN
        logic        split;
        logic [31:0] wdata1;
        logic [3:0]  be1;
`endif
    } entry_t;

    entry_t      fifo_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    state_e      state_q, state_d;
    logic        err_valid_q;
    logic [31:0] err_addr_q;

    entry_t      new_e, head;
    logic [1:0]  o;
    logic        is_half, is_word, misaligned, reject;
    logic        full, empty, push, err_accept, hs, pop;
`ifdef MISALIGN_SPLIT_EN
    logic [2:0]  n_bytes, end_lane;
`endif

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign req_ready = !full;
    assign busy      = !empty;
    assign dbg_state = state_q;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;

    // Lane steering is done at enqueue so the memory side only muxes stored beats.
    always_comb begin
        o          = req_addr[1:0];
        is_half    = (req_size == 2'b01);
        is_word    = (req_size == 2'b10);
        misaligned = (is_half && o[0]) || (is_word && (o != 2'b00));
        new_e      = '0;
        new_e.waddr = req_addr[31:2];
        case (req_size)
            2'b00: begin
                new_e.wdata0 = {4{req_data[7:0]}};
                new_e.be0    = 4'b0001 << o;
            end
            2'b01: begin
                new_e.wdata0 = {2{req_data[15:0]}};
                new_e.be0    = o[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                new_e.wdata0 = req_data;
                new_e.be0    = 4'b1111;
            end
        endcase
`ifdef MISALIGN_SPLIT_EN
        n_bytes  = is_word ? 3'd4 : 3'd2;
        end_lane = {1'b0, o} + n_bytes;
        reject   = (req_size == 2'b11);
        if (misaligned) begin
            new_e.wdata0 = req_data << {o, 3'b000};
            new_e.be0    = (is_word ? 4'b1111 : 4'b0011) << o;
            // A half at offset 1 stays inside one word; only stores running past lane 3 need a second beat.
            if (end_lane > 3'd4) begin
                new_e.split  = 1'b1;
                new_e.wdata1 = req_data >> (6'd32 - {1'b0, o, 3'b000});
                new_e.be1    = ~(4'b1111 << (end_lane - 3'd4));
            end
        end
`else
        reject = (req_size == 2'b11) || misaligned;
`endif
    end

    assign push       = req_valid && req_ready && !reject;
    assign err_accept = req_valid && req_ready && reject;

    always_comb begin
        head      = fifo_q[rd_ptr_q[AW-1:0]];
        mem_valid = !empty;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_be    = 4'd0;
        if (!empty) begin
            mem_addr  = {head.waddr, 2'b00};
            mem_wdata = head.wdata0;
            mem_be    = head.be0;
`ifdef MISALIGN_SPLIT_EN
            if (state_q == SECOND) begin
                mem_addr  = {head.waddr + 30'd1, 2'b00};
                mem_wdata = head.wdata1;
                mem_be    = head.be1;
            end
`endif
        end
    end

    always_comb begin
        hs      = mem_valid && mem_ready;
        pop     = 1'b0;
        state_d = state_q;
        case (state_q)
            FIRST: begin
                if (hs) begin
`ifdef MISALIGN_SPLIT_EN
                    if (head.split) state_d = SECOND;
                    else            pop     = 1'b1;
`else
                    pop = 1'b1;
`endif
                end
            end
            SECOND: begin
                if (hs) begin
                    pop     = 1'b1;
                    state_d = FIRST;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= FIRST;
            err_valid_q <= 1'b0;
            err_addr_q  <= 32'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            state_q     <= state_d;
            err_valid_q <= err_accept;
            if (err_accept) err_addr_q <= req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[AW-1:0]] <= new_e;
    end

endmodule
